// File: rtl/rx_frame_parser_if.sv
// -----------------------------------------------------------------------------
// rx_frame_parser_if
// Character bus from the UART receiver into the frame parser.
//   rx_data  [6:0]  received 7-bit character
//   rx_valid        1-cycle strobe, rx_data/rx_perr valid
//   rx_perr         even-parity error flag for the current character
// Modports: master drives the bus (UART receiver / bench), slave consumes it.
// -----------------------------------------------------------------------------
interface rx_frame_parser_if;
   logic [6:0] rx_data;
   logic       rx_valid;
   logic       rx_perr;

   modport master (output rx_data, output rx_valid, output rx_perr);
   modport slave  (input  rx_data, input  rx_valid, input  rx_perr);
endinterface

// File: rtl/rx_frame_parser.sv
// -----------------------------------------------------------------------------
// rx_frame_parser
// Assembles a 15-digit ASCII configuration frame from the UART receiver:
//   humidity(3) melody(1) pot(1) plant_type(1) hours(2) minutes(2) lux(5)
// Each field is converted to binary in staging registers while the frame
// arrives; the seven config outputs load together only when a complete,
// range-checked frame has been received.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   rx_if (slave)     rx_data / rx_valid / rx_perr from the UART receiver
//   humidity..lux     committed configuration (registered)
//   frame_valid       1-cycle pulse, new configuration committed
//   frame_err         1-cycle pulse, frame rejected
//   busy              high while collecting or draining a bad frame
// -----------------------------------------------------------------------------
module rx_frame_parser #(
   parameter int TIMEOUT_CYC = 13020,
   parameter int MAX_HOURS   = 23,
   parameter int MAX_MINUTES = 59
) (
   input  logic               clk,
   input  logic               rst,
   rx_frame_parser_if.slave   rx_if,
   output logic [9:0]         humidity,
   output logic [3:0]         melody,
   output logic [3:0]         pot,
   output logic [3:0]         plant_type,
   output logic [4:0]         hours,
   output logic [5:0]         minutes,
   output logic [16:0]        lux,
   output logic               frame_valid,
   output logic               frame_err,
   output logic               busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;

   localparam logic [3:0] LAST_IDX  = 4'd14;

   // control state
   logic [1:0]       r_state;
   logic [3:0]       r_idx;
   logic [CNT_W-1:0] r_idle_cnt;

   // staging accumulators; hours/minutes hold up to 99 before the range check
   logic [9:0]       r_hum;
   logic [3:0]       r_mel;
   logic [3:0]       r_pot;
   logic [3:0]       r_plant;
   logic [6:0]       r_hrs;
   logic [6:0]       r_min;
   logic [16:0]      r_lux;

   // committed configuration
   logic [9:0]       r_humidity;
   logic [3:0]       r_melody;
   logic [3:0]       r_pot_out;
   logic [3:0]       r_plant_type;
   logic [4:0]       r_hours;
   logic [5:0]       r_minutes;
   logic [16:0]      r_lux_out;
   logic             r_frame_valid;
   logic             r_frame_err;

   logic             w_legal;
   logic [3:0]       w_digit;
   logic             w_timeout;
   logic             w_store;
   logic             w_first;
   logic             w_range_ok;
   logic [9:0]       w_hum_next;
   logic [6:0]       w_hrs_next;
   logic [6:0]       w_min_next;
   logic [16:0]      w_lux_next;

   // For '0'..'9' the low nibble already is the digit value.
   assign w_legal = !rx_if.rx_perr && (rx_if.rx_data >= 7'h30) && (rx_if.rx_data <= 7'h39);
   assign w_digit = rx_if.rx_data[3:0];

   // Timeout is judged on the counter alone, so it wins over a coincident strobe.
   assign w_timeout = (r_state != S_IDLE) && (r_idle_cnt == CNT_W'(TIMEOUT_CYC));

   assign w_first = (r_state == S_IDLE) && rx_if.rx_valid && w_legal;
   assign w_store = (r_state == S_COLLECT) && rx_if.rx_valid && !w_timeout && w_legal;

   // acc*10 + digit as shift-add
   assign w_hum_next = (r_hum << 3) + (r_hum << 1) + {6'd0, w_digit};
   assign w_hrs_next = (r_hrs << 3) + (r_hrs << 1) + {3'd0, w_digit};
   assign w_min_next = (r_min << 3) + (r_min << 1) + {3'd0, w_digit};
   assign w_lux_next = (r_lux << 3) + (r_lux << 1) + {13'd0, w_digit};

   assign w_range_ok = (r_hrs <= 7'(MAX_HOURS)) && (r_min <= 7'(MAX_MINUTES));

   // Staging registers. Each field's first digit overwrites its accumulator,
   // so leftovers from an aborted frame never leak into the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hum   <= '0;
         r_mel   <= '0;
         r_pot   <= '0;
         r_plant <= '0;
         r_hrs   <= '0;
         r_min   <= '0;
         r_lux   <= '0;
      end else if (w_first) begin
         r_hum <= {6'd0, w_digit};
      end else if (w_store) begin
         case (r_idx)
            4'd1, 4'd2:                r_hum   <= w_hum_next;
            4'd3:                      r_mel   <= w_digit;
            4'd4:                      r_pot   <= w_digit;
            4'd5:                      r_plant <= w_digit;
            4'd6:                      r_hrs   <= {3'd0, w_digit};
            4'd7:                      r_hrs   <= w_hrs_next;
            4'd8:                      r_min   <= {3'd0, w_digit};
            4'd9:                      r_min   <= w_min_next;
            4'd10:                     r_lux   <= {13'd0, w_digit};
            4'd11, 4'd12, 4'd13:       r_lux   <= w_lux_next;
            default:                   r_lux   <= r_lux;  // idx 14 commits straight from w_lux_next
         endcase
      end
   end

   // Frame FSM, idle counter, commit and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_idle_cnt    <= '0;
         r_humidity    <= '0;
         r_melody      <= '0;
         r_pot_out     <= '0;
         r_plant_type  <= '0;
         r_hours       <= '0;
         r_minutes     <= '0;
         r_lux_out     <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_idle_cnt <= '0;
               r_idx      <= '0;
               if (rx_if.rx_valid) begin
                  if (w_legal) begin
                     r_idx   <= 4'd1;
                     r_state <= S_COLLECT;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_DRAIN;
                  end
               end
            end
            S_COLLECT: begin
               if (w_timeout) begin
                  r_frame_err <= 1'b1;
                  r_state     <= S_IDLE;
                  r_idx       <= '0;
                  r_idle_cnt  <= '0;
               end else if (rx_if.rx_valid) begin
                  r_idle_cnt <= '0;
                  if (!w_legal) begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_DRAIN;
                     r_idx       <= '0;
                  end else if (r_idx == LAST_IDX) begin
                     r_state <= S_IDLE;
                     r_idx   <= '0;
                     if (w_range_ok) begin
                        r_humidity    <= r_hum;
                        r_melody      <= r_mel;
                        r_pot_out     <= r_pot;
                        r_plant_type  <= r_plant;
                        r_hours       <= r_hrs[4:0];
                        r_minutes     <= r_min[5:0];
                        r_lux_out     <= w_lux_next;
                        r_frame_valid <= 1'b1;
                     end else begin
                        r_frame_err <= 1'b1;
                     end
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end else begin
                  r_idle_cnt <= r_idle_cnt + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               if (w_timeout) begin
                  r_state    <= S_IDLE;
                  r_idle_cnt <= '0;
               end else if (rx_if.rx_valid) begin
                  r_idle_cnt <= '0;
               end else begin
                  r_idle_cnt <= r_idle_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_idx      <= '0;
               r_idle_cnt <= '0;
            end
         endcase
      end
   end

   assign humidity    = r_humidity;
   assign melody      = r_melody;
   assign pot         = r_pot_out;
   assign plant_type  = r_plant_type;
   assign hours       = r_hours;
   assign minutes     = r_minutes;
   assign lux         = r_lux_out;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rx_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_parser
// Directed bench for rx_frame_parser: good frames, parity/non-digit aborts,
// range rejects, inter-byte timeout, back-to-back frames and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_rx_frame_parser;

   localparam int TO = 13020;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  humidity;
   logic [3:0]  melody;
   logic [3:0]  pot;
   logic [3:0]  plant_type;
   logic [4:0]  hours;
   logic [5:0]  minutes;
   logic [16:0] lux;
   logic        frame_valid;
   logic        frame_err;
   logic        busy;

   int vecs   = 0;
   int errs   = 0;
   int fv_cnt = 0;
   int fe_cnt = 0;
   int fv0;
   int fe0;

   always #10 clk = ~clk;

   rx_frame_parser_if rx_bus ();

   rx_frame_parser #(
      .TIMEOUT_CYC (TO),
      .MAX_HOURS   (23),
      .MAX_MINUTES (59)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_if       (rx_bus),
      .humidity    (humidity),
      .melody      (melody),
      .pot         (pot),
      .plant_type  (plant_type),
      .hours       (hours),
      .minutes     (minutes),
      .lux         (lux),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   // pulse counters, sampled just after each active edge
   always @(posedge clk) begin
      #1;
      if (frame_valid === 1'b1) fv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
   end

   task automatic send_byte(input logic [6:0] d, input logic perr);
      @(negedge clk);
      rx_bus.rx_data  = d;
      rx_bus.rx_perr  = perr;
      rx_bus.rx_valid = 1'b1;
      @(negedge clk);
      rx_bus.rx_valid = 1'b0;
      rx_bus.rx_perr  = 1'b0;
   endtask

   // sends characters first..last of s; returns on the negedge right after the last strobe
   task automatic send_str(input string s, input int first, input int last, input int perr_pos);
      for (int i = first; i <= last; i++) begin
         if (i > first) repeat (2) @(negedge clk);
         send_byte(7'(s[i]), (i == perr_pos));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_bus.rx_valid = 1'b0;
      rx_bus.rx_perr  = 1'b0;
      rx_bus.rx_data  = 7'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      vecs++;
      if ({humidity, melody, pot, plant_type, hours, minutes, lux} !== 50'd0) begin
         errs++;
         $display("FAIL reset_cfg: got hum=%0d mel=%0d pot=%0d plant=%0d hrs=%0d min=%0d lux=%0d, want all 0",
                  humidity, melody, pot, plant_type, hours, minutes, lux);
      end
      vecs++;
      if ({frame_valid, frame_err, busy} !== 3'b000) begin
         errs++;
         $display("FAIL reset_flags: got fv=%b fe=%b busy=%b, want 0 0 0", frame_valid, frame_err, busy);
      end
      $display("test_reset done");
   endtask

   task automatic test_good_frame();
      fv0 = fv_cnt;
      send_str("065313103204967", 0, 13, -1);
      vecs++;
      if (humidity !== 10'd0 || frame_valid !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL t1_no_partial: got hum=%0d fv=%b busy=%b, want 0 0 1", humidity, frame_valid, busy);
      end
      send_str("065313103204967", 14, 14, -1);
      vecs++;
      if (frame_valid !== 1'b1 || frame_err !== 1'b0) begin
         errs++;
         $display("FAIL t1_pulse: got fv=%b fe=%b, want 1 0", frame_valid, frame_err);
      end
      vecs++;
      if ({humidity, melody, pot, plant_type, hours, minutes, lux} !==
          {10'd65, 4'd3, 4'd1, 4'd3, 5'd10, 6'd32, 17'd4967}) begin
         errs++;
         $display("FAIL t1_cfg: got hum=%0d mel=%0d pot=%0d plant=%0d hrs=%0d min=%0d lux=%0d, want 65/3/1/3/10/32/4967",
                  humidity, melody, pot, plant_type, hours, minutes, lux);
      end
      @(negedge clk);
      vecs++;
      if (frame_valid !== 1'b0 || (fv_cnt - fv0) != 1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL t1_one_cycle: got fv=%b pulses=%0d busy=%b, want 0 1 0", frame_valid, fv_cnt - fv0, busy);
      end
      $display("test_good_frame done");
   endtask

   task automatic test_parity_drain();
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_str("065313103204967", 0, 4, 4);
      vecs++;
      if (frame_err !== 1'b1 || frame_valid !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL t2_perr: got fe=%b fv=%b busy=%b, want 1 0 1", frame_err, frame_valid, busy);
      end
      send_str("065313103204967", 5, 14, -1);
      vecs++;
      if ((fe_cnt - fe0) != 1 || fv_cnt != fv0 || busy !== 1'b1 ||
          {humidity, melody, pot, plant_type, hours, minutes, lux} !==
          {10'd65, 4'd3, 4'd1, 4'd3, 5'd10, 6'd32, 17'd4967}) begin
         errs++;
         $display("FAIL t2_drain: got fe_pulses=%0d fv_pulses=%0d busy=%b min=%0d lux=%0d, want 1 0 1 32 4967",
                  fe_cnt - fe0, fv_cnt - fv0, busy, minutes, lux);
      end
      repeat (TO + 5) @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || (fe_cnt - fe0) != 1 || fv_cnt != fv0) begin
         errs++;
         $display("FAIL t2_drain_exit: got busy=%b fe_pulses=%0d fv_pulses=%0d, want 0 1 0",
                  busy, fe_cnt - fe0, fv_cnt - fv0);
      end
      send_str("065313103304967", 0, 14, -1);
      vecs++;
      if (frame_valid !== 1'b1 || {humidity, melody, pot, plant_type, hours, minutes, lux} !==
          {10'd65, 4'd3, 4'd1, 4'd3, 5'd10, 6'd33, 17'd4967}) begin
         errs++;
         $display("FAIL t2_recover: got fv=%b hum=%0d hrs=%0d min=%0d lux=%0d, want 1 65 10 33 4967",
                  frame_valid, humidity, hours, minutes, lux);
      end
      $display("test_parity_drain done");
   endtask

   task automatic test_range_fail();
      // hours 25
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_str("000000250000000", 0, 14, -1);
      vecs++;
      if (frame_err !== 1'b1 || frame_valid !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL t3_hours_pulse: got fe=%b fv=%b busy=%b, want 1 0 0", frame_err, frame_valid, busy);
      end
      vecs++;
      if ({humidity, hours, minutes, lux} !== {10'd65, 5'd10, 6'd33, 17'd4967}) begin
         errs++;
         $display("FAIL t3_hours_hold: got hum=%0d hrs=%0d min=%0d lux=%0d, want 65 10 33 4967",
                  humidity, hours, minutes, lux);
      end
      // minutes 60 with hours at its limit
      send_str("000000236000000", 0, 14, -1);
      vecs++;
      if (frame_err !== 1'b1 || (fe_cnt - fe0) != 2 || fv_cnt != fv0 || minutes !== 6'd33) begin
         errs++;
         $display("FAIL t3_minutes: got fe=%b fe_pulses=%0d fv_pulses=%0d min=%0d, want 1 2 0 33",
                  frame_err, fe_cnt - fe0, fv_cnt - fv0, minutes);
      end
      $display("test_range_fail done");
   endtask

   task automatic test_non_digit();
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_byte(7'h41, 1'b0);
      vecs++;
      if (frame_err !== 1'b1 || busy !== 1'b1) begin
         errs++;
         $display("FAIL t4_alpha: got fe=%b busy=%b, want 1 1", frame_err, busy);
      end
      send_str("123456120534567", 0, 14, -1);
      vecs++;
      if ((fe_cnt - fe0) != 1 || fv_cnt != fv0 || busy !== 1'b1 || humidity !== 10'd65) begin
         errs++;
         $display("FAIL t4_ignored: got fe_pulses=%0d fv_pulses=%0d busy=%b hum=%0d, want 1 0 1 65",
                  fe_cnt - fe0, fv_cnt - fv0, busy, humidity);
      end
      repeat (TO + 5) @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || (fe_cnt - fe0) != 1) begin
         errs++;
         $display("FAIL t4_drain_exit: got busy=%b fe_pulses=%0d, want 0 1", busy, fe_cnt - fe0);
      end
      // ':' sits just above '9' and must abort a frame in progress
      send_str("065", 0, 2, -1);
      send_byte(7'h3A, 1'b0);
      vecs++;
      if (frame_err !== 1'b1 || busy !== 1'b1 || (fe_cnt - fe0) != 2) begin
         errs++;
         $display("FAIL t4_colon: got fe=%b busy=%b fe_pulses=%0d, want 1 1 2", frame_err, busy, fe_cnt - fe0);
      end
      repeat (TO + 5) @(negedge clk);
      $display("test_non_digit done");
   endtask

   task automatic test_timeout();
      int n;
      fv0 = fv_cnt;
      send_str("123456120534567", 0, 7, -1);
      n = 0;
      while (frame_err !== 1'b1 && n < TO + 20) begin
         @(negedge clk);
         n++;
      end
      vecs++;
      if (frame_err !== 1'b1 || n < TO || n > TO + 2) begin
         errs++;
         $display("FAIL t5_timeout: got fe=%b after %0d idle cycles, want 1 after %0d..%0d", frame_err, n, TO, TO + 2);
      end
      vecs++;
      if (busy !== 1'b0 || humidity !== 10'd65) begin
         errs++;
         $display("FAIL t5_idle: got busy=%b hum=%0d, want 0 65", busy, humidity);
      end
      send_str("123456120534567", 0, 14, -1);
      vecs++;
      if (frame_valid !== 1'b1 || (fv_cnt - fv0) != 1 ||
          {humidity, melody, pot, plant_type, hours, minutes, lux} !==
          {10'd123, 4'd4, 4'd5, 4'd6, 5'd12, 6'd5, 17'd34567}) begin
         errs++;
         $display("FAIL t5_fresh: got fv=%b hum=%0d mel=%0d pot=%0d plant=%0d hrs=%0d min=%0d lux=%0d, want 1 123/4/5/6/12/5/34567",
                  frame_valid, humidity, melody, pot, plant_type, hours, minutes, lux);
      end
      $display("test_timeout done");
   endtask

   task automatic test_back_to_back();
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_str("065313103204967", 0, 14, -1);
      send_str("123456120534567", 0, 14, -1);
      vecs++;
      if ((fv_cnt - fv0) != 2 || fe_cnt != fe0 ||
          {humidity, melody, pot, plant_type, hours, minutes, lux} !==
          {10'd123, 4'd4, 4'd5, 4'd6, 5'd12, 6'd5, 17'd34567}) begin
         errs++;
         $display("FAIL b2b: got fv_pulses=%0d fe_pulses=%0d hum=%0d min=%0d lux=%0d, want 2 0 123 5 34567",
                  fv_cnt - fv0, fe_cnt - fe0, humidity, minutes, lux);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_midframe();
      send_str("065313103204967", 0, 14, -1);
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_str("999999235999999", 0, 9, -1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vecs++;
      if ({humidity, melody, pot, plant_type, hours, minutes, lux} !== 50'd0 ||
          {frame_valid, frame_err, busy} !== 3'b000 || fv_cnt != fv0 || fe_cnt != fe0) begin
         errs++;
         $display("FAIL t6_rst: got hum=%0d lux=%0d fv=%b fe=%b busy=%b pulses=%0d/%0d, want all 0",
                  humidity, lux, frame_valid, frame_err, busy, fv_cnt - fv0, fe_cnt - fe0);
      end
      send_str("999999235999999", 0, 14, -1);
      vecs++;
      if (frame_valid !== 1'b1 || {humidity, melody, pot, plant_type, hours, minutes, lux} !==
          {10'd999, 4'd9, 4'd9, 4'd9, 5'd23, 6'd59, 17'd99999}) begin
         errs++;
         $display("FAIL t6_max: got fv=%b hum=%0d mel=%0d pot=%0d plant=%0d hrs=%0d min=%0d lux=%0d, want 1 999/9/9/9/23/59/99999",
                  frame_valid, humidity, melody, pot, plant_type, hours, minutes, lux);
      end
      $display("test_reset_midframe done");
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity_drain();
      test_range_fail();
      test_non_digit();
      test_timeout();
      test_back_to_back();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
